// File: rtl/pump_axi_bridge.sv
// Bridges pump rd_en/wr_en word requests onto an AXI4-Lite master port.
// One transaction in flight, one pending slot per direction, timeout and sticky errors.
module pump_axi_bridge #(
    parameter int          TIMEOUT_CYCLES = 1024,
    parameter logic [31:0] ERR_DATA       = 32'hDEAD_BEEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic [31:0] rd_addr,
    output logic        rd_valid,
    output logic [31:0] rd_data,
    output logic        rd_done,
    input  logic        wr_en,
    input  logic [31:0] wr_addr,
    input  logic [31:0] wr_data,
    output logic        wr_done,
    output logic [31:0] m_axi_araddr,
    output logic        m_axi_arvalid,
    output logic [2:0]  m_axi_arprot,
    input  logic        m_axi_arready,
    input  logic [31:0] m_axi_rdata,
    input  logic [1:0]  m_axi_rresp,
    input  logic        m_axi_rvalid,
    output logic        m_axi_rready,
    output logic [31:0] m_axi_awaddr,
    output logic        m_axi_awvalid,
    output logic [2:0]  m_axi_awprot,
    input  logic        m_axi_awready,
    output logic [31:0] m_axi_wdata,
    output logic [3:0]  m_axi_wstrb,
    output logic        m_axi_wvalid,
    input  logic        m_axi_wready,
    input  logic [1:0]  m_axi_bresp,
    input  logic        m_axi_bvalid,
    output logic        m_axi_bready,
    output logic        busy,
    output logic        err_resp,
    output logic        err_timeout,
    output logic        err_overflow,
    input  logic        err_clear
);

    typedef enum logic [2:0] {IDLE, RD_ADDR, RD_RESP, WR_REQ, WR_RESP} state_t;

    localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

    state_t      state, state_nx;
    logic        rd_full, wr_full;
    logic [31:0] rd_slot_addr, wr_slot_addr, wr_slot_data;
    logic [31:0] txn_addr, txn_data;
    logic        aw_done, w_done;
    logic [15:0] cnt;

    logic timeout, to_fire, rd_to, wr_to;
    logic ar_hs, r_hs, aw_hs, w_hs, b_hs;
    logic take_rd, take_wr;

    assign ar_hs   = m_axi_arvalid && m_axi_arready;
    assign r_hs    = m_axi_rready && m_axi_rvalid;
    assign aw_hs   = m_axi_awvalid && m_axi_awready;
    assign w_hs    = m_axi_wvalid && m_axi_wready;
    assign b_hs    = m_axi_bready && m_axi_bvalid;
    assign take_rd = (state == IDLE) && rd_full;
    assign take_wr = (state == IDLE) && !rd_full && wr_full;

    assign timeout = (TIMEOUT_CYCLES != 0) && (state != IDLE) && (cnt == TO_LIMIT);
    // Only a timeout can send a non-IDLE state to IDLE without a final handshake.
    assign to_fire = timeout && (state_nx == IDLE) && !r_hs && !b_hs;
    assign rd_to   = to_fire && (state == RD_ADDR || state == RD_RESP);
    assign wr_to   = to_fire && (state == WR_REQ || state == WR_RESP);

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE: begin
                if (rd_full)      state_nx = RD_ADDR;
                else if (wr_full) state_nx = WR_REQ;
            end
            RD_ADDR: begin
                if (ar_hs)        state_nx = RD_RESP;
                else if (timeout) state_nx = IDLE;
            end
            RD_RESP: begin
                if (r_hs || timeout) state_nx = IDLE;
            end
            WR_REQ: begin
                if ((aw_done || aw_hs) && (w_done || w_hs)) state_nx = WR_RESP;
                else if (timeout)                           state_nx = IDLE;
            end
            WR_RESP: begin
                if (b_hs || timeout) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    assign m_axi_araddr  = {txn_addr[31:2], 2'b00};
    assign m_axi_awaddr  = {txn_addr[31:2], 2'b00};
    assign m_axi_arprot  = 3'b000;
    assign m_axi_awprot  = 3'b000;
    assign m_axi_arvalid = (state == RD_ADDR);
    assign m_axi_rready  = (state == RD_RESP);
    assign m_axi_awvalid = (state == WR_REQ) && !aw_done;
    assign m_axi_wvalid  = (state == WR_REQ) && !w_done;
    assign m_axi_wdata   = txn_data;
    assign m_axi_wstrb   = {4{m_axi_wvalid}};
    assign m_axi_bready  = (state == WR_RESP);
    assign busy          = (state != IDLE) || rd_full || wr_full;

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            rd_full      <= 1'b0;
            wr_full      <= 1'b0;
            rd_slot_addr <= '0;
            wr_slot_addr <= '0;
            wr_slot_data <= '0;
            txn_addr     <= '0;
            txn_data     <= '0;
            aw_done      <= 1'b0;
            w_done       <= 1'b0;
            rd_valid     <= 1'b0;
            rd_done      <= 1'b0;
            rd_data      <= '0;
            wr_done      <= 1'b0;
            err_resp     <= 1'b0;
            err_timeout  <= 1'b0;
            err_overflow <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= (state == IDLE || state_nx != state) ? 16'd0 : cnt + 16'd1;

            // A slot being drained this cycle may be refilled in the same cycle.
            if (rd_en && (!rd_full || take_rd)) begin
                rd_full      <= 1'b1;
                rd_slot_addr <= rd_addr;
            end else if (take_rd) begin
                rd_full <= 1'b0;
            end

            if (wr_en && (!wr_full || take_wr)) begin
                wr_full      <= 1'b1;
                wr_slot_addr <= wr_addr;
                wr_slot_data <= wr_data;
            end else if (take_wr) begin
                wr_full <= 1'b0;
            end

            if (take_rd) begin
                txn_addr <= rd_slot_addr;
            end else if (take_wr) begin
                txn_addr <= wr_slot_addr;
                txn_data <= wr_slot_data;
            end

            aw_done <= (state == WR_REQ && state_nx == WR_REQ) && (aw_done || aw_hs);
            w_done  <= (state == WR_REQ && state_nx == WR_REQ) && (w_done || w_hs);

            rd_done  <= r_hs || rd_to;
            rd_valid <= r_hs || rd_to;
            wr_done  <= b_hs || wr_to;
            if (r_hs)       rd_data <= m_axi_rdata;
            else if (rd_to) rd_data <= ERR_DATA;

            err_resp <= (err_resp && !err_clear)
                     || (r_hs && m_axi_rresp != 2'b00)
                     || (b_hs && m_axi_bresp != 2'b00);
            err_timeout <= (err_timeout && !err_clear) || to_fire;
            err_overflow <= (err_overflow && !err_clear)
                         || (rd_en && rd_full && !take_rd)
                         || (wr_en && wr_full && !take_wr);
        end
    end

endmodule
